cpu_sequencer: RTL

Multi-cycle instruction sequencer for the 16-bit CPU. It walks each instruction through fetch, decode, operand load, execute and writeback. In each phase it drives the one-hot-per-phase datapath strobes: ins_load, op1_load, op2_load, alu_ot, pc_load, pc_inc and reg_load. It sits between the instruction memory handshake and the register/ALU datapath, and counts retired instructions.

---
 rtl/cpu_pkg.sv | 56 +++++
 rtl/cpu_seq_decode.sv | 72 +++++++
 rtl/cpu_sequencer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared types, opcode map and helpers for the 16-bit CPU instruction sequencer.
package cpu_pkg;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        OP1    = 4'd3,
        OP2    = 4'd4,
        EXEC   = 4'd5,
        WB     = 4'd6,
        HALTED = 4'd7,
        FAULT  = 4'd8
    } state_t;

    typedef enum logic [2:0] {
        CLS_NOP   = 3'd0,
        CLS_ADDR  = 3'd1,
        CLS_ARITH = 3'd2,
        CLS_LOGIC = 3'd3,
        CLS_JMP   = 3'd4,
        CLS_HALT  = 3'd5
    } op_class_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_MOV  = 4'h3;
    localparam logic [3:0] OP_NOT  = 4'hD;
    localparam logic [3:0] OP_JMP  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [1:0] ALU_ADDR  = 2'b00;
    localparam logic [1:0] ALU_ARITH = 2'b01;
    localparam logic [1:0] ALU_LOGIC = 2'b10;
    localparam logic [1:0] ALU_IDLE  = 2'b11;

    // Unary instructions read a single source operand and skip OP2.
    function automatic logic is_unary(input logic [3:0] op);
        return (op == OP_MOV) || (op == OP_NOT);
    endfunction

    function automatic op_class_t op_class(input logic [3:0] op);
        op_class_t cls;
        case (op)
            4'h0:                      cls = CLS_NOP;
            4'h1, 4'h2, 4'h3:          cls = CLS_ADDR;
            4'h4, 4'h5, 4'h6,
            4'h7, 4'h8, 4'h9:          cls = CLS_ARITH;
            4'hA, 4'hB, 4'hC, 4'hD:    cls = CLS_LOGIC;
            4'hE:                      cls = CLS_JMP;
            4'hF:                      cls = CLS_HALT;
            default:                   cls = CLS_NOP;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/cpu_seq_decode.sv
// Combinational map from sequencer state (plus the instruction opcode) to
// datapath strobes and ALU mode. The only dependence on a live handshake
// input is ins_load, which follows mem_ack while fetching.
module cpu_seq_decode
    import cpu_pkg::*;
(
    input  state_t     state,
    input  logic [3:0] opcode,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       ins_load,
    output logic       op1_load,
    output logic       op2_load,
    output logic [1:0] alu_ot,
    output logic       pc_load,
    output logic       pc_inc,
    output logic       reg_load,
    output logic       halted
);

    // Per-state strobe decode; everything idles unless a state claims it.
    always_comb begin
        mem_req  = 1'b0;
        ins_load = 1'b0;
        op1_load = 1'b0;
        op2_load = 1'b0;
        alu_ot   = ALU_IDLE;
        pc_load  = 1'b0;
        pc_inc   = 1'b0;
        reg_load = 1'b0;
        halted   = 1'b0;
        case (state)
            FETCH: begin
                mem_req  = 1'b1;
                ins_load = mem_ack;
            end
            DECODE: begin
                // NOP retires straight out of DECODE, so it advances the PC here.
                pc_inc = (op_class(opcode) == CLS_NOP);
            end
            OP1: begin
                op1_load = 1'b1;
            end
            OP2: begin
                op2_load = 1'b1;
            end
            EXEC: begin
                case (op_class(opcode))
                    CLS_ADDR:  alu_ot = ALU_ADDR;
                    CLS_ARITH: alu_ot = ALU_ARITH;
                    CLS_LOGIC: alu_ot = ALU_LOGIC;
                    CLS_JMP: begin
                        alu_ot  = ALU_ADDR;
                        pc_load = 1'b1;
                    end
                    default:   alu_ot = ALU_IDLE;
                endcase
            end
            WB: begin
                reg_load = 1'b1;
                pc_inc   = 1'b1;
            end
            HALTED: begin
                halted = 1'b1;
            end
            default: begin
                mem_req = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/OP1/OP2/EXEC/WB walk,
// retired-instruction counter and optional fetch timeout.
// Optional feature macro: SEQ_TIMEOUT_EN (fetch-wait timeout to FAULT state).
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 15
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [3:0]       opcode,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             ins_load,
    output logic             op1_load,
    output logic             op2_load,
    output logic [1:0]       alu_ot,
    output logic             pc_load,
    output logic             pc_inc,
    output logic             reg_load,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] instr_count
);

    state_t           state_r;
    state_t           state_nx_s;
    logic [3:0]       op_r;
    logic [3:0]       dec_op_s;
    logic             retire_s;
    logic             timeout_s;
    logic [CNT_W-1:0] cnt_r;

`ifdef SEQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_r;

    // Fetch-wait counter: cleared outside FETCH, counts unacknowledged FETCH cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tmo_r <= {TMO_W{1'b0}};
        end else if (state_r != FETCH) begin
            tmo_r <= {TMO_W{1'b0}};
        end else if (!mem_ack) begin
            tmo_r <= tmo_r + TMO_W'(1);
        end else begin
            tmo_r <= tmo_r;
        end
    end

    // The limit is reached on the cycle the counter would hit TIMEOUT_CYCLES;
    // an ack in that same cycle takes priority.
    assign timeout_s = (tmo_r == TMO_W'(TIMEOUT_CYCLES - 1)) && !mem_ack;
    assign fault     = (state_r == FAULT);
`else
    assign timeout_s = 1'b0;
    assign fault     = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Hold the opcode seen in DECODE so later phases do not depend on the live input.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_r <= 4'h0;
        end else if (state_r == DECODE) begin
            op_r <= opcode;
        end else begin
            op_r <= op_r;
        end
    end

    // Retired-instruction counter, wraps modulo 2^CNT_W.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (retire_s) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Next-state and retire decision.
    always_comb begin
        state_nx_s = state_r;
        retire_s   = 1'b0;
        case (state_r)
            IDLE: begin
                state_nx_s = run ? FETCH : IDLE;
            end
            FETCH: begin
                if (mem_ack) begin
                    state_nx_s = DECODE;
                end else if (timeout_s) begin
                    state_nx_s = FAULT;
                end else begin
                    state_nx_s = FETCH;
                end
            end
            DECODE: begin
                case (op_class(opcode))
                    CLS_NOP: begin
                        state_nx_s = FETCH;
                        retire_s   = 1'b1;
                    end
                    CLS_HALT: begin
                        state_nx_s = HALTED;
                        retire_s   = 1'b1;
                    end
                    default: state_nx_s = OP1;
                endcase
            end
            OP1: begin
                if ((op_class(op_r) == CLS_JMP) || is_unary(op_r)) begin
                    state_nx_s = EXEC;
                end else begin
                    state_nx_s = OP2;
                end
            end
            OP2: begin
                state_nx_s = EXEC;
            end
            EXEC: begin
                if (op_class(op_r) == CLS_JMP) begin
                    state_nx_s = FETCH;
                    retire_s   = 1'b1;
                end else begin
                    state_nx_s = WB;
                end
            end
            WB: begin
                state_nx_s = FETCH;
                retire_s   = 1'b1;
            end
            HALTED: begin
                state_nx_s = HALTED;
            end
            FAULT: begin
                state_nx_s = FAULT;
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // DECODE looks at the live instruction register; later phases use the held copy.
    assign dec_op_s    = (state_r == DECODE) ? opcode : op_r;
    assign instr_count = cnt_r;

    cpu_seq_decode u_decode (
        .state    (state_r),
        .opcode   (dec_op_s),
        .mem_ack  (mem_ack),
        .mem_req  (mem_req),
        .ins_load (ins_load),
        .op1_load (op1_load),
        .op2_load (op2_load),
        .alu_ot   (alu_ot),
        .pc_load  (pc_load),
        .pc_inc   (pc_inc),
        .reg_load (reg_load),
        .halted   (halted)
    );

endmodule
